fpany_accum_ctrl: RTL and testbench

FPANY_ACCUM_CTRL -- requirements
Module: fpany_accum_ctrl

---
 rtl/fpany_accum_ctrl_pkg.sv | 40 ++++
 rtl/fpany_accum_ctrl_adder.sv | 79 +++++++
 rtl/fpany_accum_ctrl.sv | 146 ++++++++++++++
 tb/tb_fpany_accum_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpany_accum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpany_accum_ctrl_pkg
// Description : Shared widths, state encoding and constants for the
//               shared-exponent FP dot-product accumulator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fpany_accum_ctrl_pkg;

  // Accumulator FSM: IDLE holds an empty partial sum, ACCUM has folded beats
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } accum_state_t;

  // Width of one packed FP lane: sign + exponent + mantissa
  function automatic int fpany_total(input int e, input int m);
    return e + m + 1;
  endfunction

  // Width of the partial-sum mantissa field (integer + fraction bits)
  function automatic int fpany_pwidth(input int int_bits, input int frac);
    return int_bits + frac;
  endfunction

  // Width of a packed partial sum: sign + exponent + mantissa field
  function automatic int fpany_rw(input int e, input int int_bits, input int frac);
    return e + int_bits + frac + 1;
  endfunction

  // Derived widths at the default configuration
  localparam int c_total_default  = fpany_total(5, 10);
  localparam int c_pwidth_default = fpany_pwidth(4, 12);
  localparam int c_rw_default     = fpany_rw(5, 4, 12);

  // Empty partial sum; sliced to the instance's RW
  localparam logic [127:0] c_zero_psum = '0;

endpackage
`default_nettype wire

// File: rtl/fpany_accum_ctrl_adder.sv
`default_nettype none
// ============================================================================
// Module      : adder_fpany_no_norm_v2
// Description : Combinational shared-exponent adder. Folds NUM packed FP lanes
//               into a two's-complement partial sum without normalising: the
//               result exponent is the maximum of all operand exponents and
//               every operand is aligned to it by an arithmetic right shift.
//               Mantissa overflow wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_fpany_no_norm_v2
  import fpany_accum_ctrl_pkg::*;
#(
  parameter int E    = 5,
  parameter int M    = 10,
  parameter int INT  = 4,
  parameter int FRAC = 12,
  parameter int NUM  = 16
) (
  input  logic [fpany_rw(E, INT, FRAC)-1:0]  i_psum,
  input  logic [NUM*fpany_total(E, M)-1:0]   i_lanes,
  output logic [fpany_rw(E, INT, FRAC)-1:0]  o_sum
);

  localparam int TOTAL  = fpany_total(E, M);
  localparam int PWIDTH = fpany_pwidth(INT, FRAC);
  localparam int RW     = fpany_rw(E, INT, FRAC);
  localparam int SW     = PWIDTH + 1;

  logic        [E-1:0]  w_lane_exp [NUM];
  logic signed [SW-1:0] w_lane_val [NUM];
  logic        [E-1:0]  w_psum_exp;
  logic signed [SW-1:0] w_psum_val;
  logic        [E-1:0]  w_max_exp;
  logic signed [SW-1:0] w_acc;

  // Unpack each lane into an effective exponent and a signed fixed-point value
  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      logic [TOTAL-1:0] w_lane;
      logic             w_hidden;
      logic [SW-1:0]    w_mag;

      assign w_lane   = i_lanes[gi*TOTAL +: TOTAL];
      // Subnormals have no hidden bit and sit at exponent 1
      assign w_hidden = |w_lane[TOTAL-2 -: E];
      assign w_lane_exp[gi] = w_hidden ? w_lane[TOTAL-2 -: E] : E'(1);
      // Place 1.mantissa so its binary point lines up with the FRAC field
      assign w_mag = {{(SW-M-1){1'b0}}, w_hidden, w_lane[M-1:0]} << (FRAC - M);
      assign w_lane_val[gi] = w_lane[TOTAL-1] ? -$signed(w_mag) : $signed(w_mag);
    end
  endgenerate

  // Partial sum: sign bit and mantissa field together form one signed value
  assign w_psum_exp = i_psum[RW-2 -: E];
  assign w_psum_val = $signed({i_psum[RW-1], i_psum[PWIDTH-1:0]});

  // Shared exponent is the largest exponent among the partial sum and all lanes
  always_comb begin
    w_max_exp = w_psum_exp;
    for (int i = 0; i < NUM; i++) begin
      if (w_lane_exp[i] > w_max_exp) begin
        w_max_exp = w_lane_exp[i];
      end
    end
  end

  // Align every operand to the shared exponent and sum in two's complement
  always_comb begin
    w_acc = w_psum_val >>> (w_max_exp - w_psum_exp);
    for (int i = 0; i < NUM; i++) begin
      w_acc = w_acc + (w_lane_val[i] >>> (w_max_exp - w_lane_exp[i]));
    end
  end

  assign o_sum = {w_acc[SW-1], w_max_exp, w_acc[PWIDTH-1:0]};

endmodule
`default_nettype wire

// File: rtl/fpany_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpany_accum_ctrl
// Description : Dot-product accumulation controller. Folds one beat of NUM FP
//               lanes per cycle into a running shared-exponent partial sum and
//               hands the finished sum to a valid/ready consumer one cycle
//               after the last beat of each group.
// Revision    : 1.0 - initial release
// ============================================================================
module fpany_accum_ctrl
  import fpany_accum_ctrl_pkg::*;
#(
  parameter int E     = 5,
  parameter int M     = 10,
  parameter int INT   = 4,
  parameter int FRAC  = 12,
  parameter int NUM   = 16,
  parameter int CNT_W = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM*fpany_total(E, M)-1:0]    in_data,
  input  logic                                in_last,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [fpany_rw(E, INT, FRAC)-1:0]   out_data,
  output logic [CNT_W-1:0]                    out_beats,
  output logic                                ovf_err
);

  localparam int TOTAL  = fpany_total(E, M);
  localparam int PWIDTH = fpany_pwidth(INT, FRAC);
  localparam int RW     = fpany_rw(E, INT, FRAC);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  accum_state_t     r_state;
  accum_state_t     w_state_next;
  logic [RW-1:0]    r_psum;
  logic [RW-1:0]    w_next_psum;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_at_max;
  logic [RW-1:0]    r_out_data;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_valid;
  logic             r_ovf_err;
  logic             w_accept;
  logic             w_fold;
  logic             w_close;
  logic             w_clear;

  // A new beat may enter whenever the result slot is free or being drained
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign ovf_err   = r_ovf_err;

  adder_fpany_no_norm_v2 #(
    .E    (E),
    .M    (M),
    .INT  (INT),
    .FRAC (FRAC),
    .NUM  (NUM)
  ) u_adder (
    .i_psum  (r_psum),
    .i_lanes (in_data),
    .o_sum   (w_next_psum)
  );

  // Beat counter as seen by this beat, saturating at its maximum
  assign w_cnt_base = (r_state == ST_IDLE) ? '0 : r_cnt;
  assign w_at_max   = (w_cnt_base == c_cnt_max);
  assign w_cnt_inc  = w_at_max ? w_cnt_base : (w_cnt_base + CNT_W'(1));

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and datapath controls; flush overrides any accepted beat
  always_comb begin
    w_state_next = r_state;
    w_fold       = 1'b0;
    w_close      = 1'b0;
    w_clear      = 1'b0;
    if (flush) begin
      w_clear      = 1'b1;
      w_state_next = ST_IDLE;
    end else if (w_accept) begin
      if (in_last) begin
        w_close      = 1'b1;
        w_clear      = 1'b1;
        w_state_next = ST_IDLE;
      end else begin
        w_fold       = 1'b1;
        w_state_next = ST_ACCUM;
      end
    end
  end

  // Running partial sum, beat count and sticky counter overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_psum    <= c_zero_psum[RW-1:0];
      r_cnt     <= '0;
      r_ovf_err <= 1'b0;
    end else if (w_clear) begin
      r_psum    <= c_zero_psum[RW-1:0];
      r_cnt     <= '0;
    end else if (w_fold) begin
      r_psum    <= w_next_psum;
      r_cnt     <= w_cnt_inc;
      if (w_at_max) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  // Result register: reloads on a closing beat, otherwise drains on handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      r_out_data  <= w_next_psum;
      r_out_beats <= w_cnt_inc;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpany_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpany_accum_ctrl
// Description : Self-checking bench for fpany_accum_ctrl with a queue-based
//               result scoreboard, plus a CNT_W=2 instance for counter
//               saturation and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpany_accum_ctrl;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_last;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [21:0]  out_data;
  logic [7:0]   out_beats;
  logic         ovf_err;

  logic         b_reset;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [255:0] b_in_data;
  logic         b_in_last;
  logic         b_flush;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [21:0]  b_out_data;
  logic [1:0]   b_out_beats;
  logic         b_ovf_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [21:0] data;
    logic [7:0]  beats;
  } result_t;

  result_t sb_q[$];

  logic [15:0] c_pat [5] = '{16'h3C00, 16'hBC00, 16'h3E00, 16'h3800, 16'h0000};
  logic [255:0] c_one4;

  fpany_accum_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .ovf_err   (ovf_err)
  );

  fpany_accum_ctrl #(.CNT_W(2)) dut_sat (
    .clock     (clock),
    .reset     (b_reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_beats (b_out_beats),
    .ovf_err   (b_ovf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Value of one half-precision lane in units of 2^-12 at exponent 15
  function automatic int lane_q12(input logic [15:0] h);
    case (h)
      16'h3C00: return 4096;
      16'hBC00: return -4096;
      16'h3E00: return 6144;
      16'h3800: return 2048;
      default:  return 0;
    endcase
  endfunction

  function automatic int beat_q12(input logic [255:0] d);
    int s = 0;
    for (int i = 0; i < 16; i++) s += lane_q12(d[i*16 +: 16]);
    return s;
  endfunction

  // Expected packed sum: exponent 15, 17-bit wrapping two's complement value
  function automatic logic [21:0] pack_sum(input int v);
    logic [16:0] s;
    s = v[16:0];
    return {s[16], 5'd15, s[15:0]};
  endfunction

  function automatic logic [255:0] beat4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
    logic [255:0] r;
    r = '0;
    r[15:0]  = a;
    r[31:16] = b;
    r[47:32] = c;
    r[63:48] = d;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [255:0] d, input logic l, input logic f);
    @(negedge clock);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    flush    = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic b_drive(input logic v, input logic l);
    @(negedge clock);
    b_in_valid = v;
    b_in_data  = c_one4;
    b_in_last  = l;
  endtask

  // Scoreboard model of the main instance, sampled mid-cycle
  initial begin : monitor
    int      m_sum;
    int      m_cnt;
    bit      m_oval;
    bit      m_ready;
    bit      nxt;
    result_t exp_r;
    m_sum  = 0;
    m_cnt  = 0;
    m_oval = 0;
    forever begin
      @(negedge clock);
      #3;
      if (reset) begin
        m_sum  = 0;
        m_cnt  = 0;
        m_oval = 0;
        sb_q.delete();
      end else begin
        m_ready = !m_oval || out_ready;
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_oval);
        if (m_oval && out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_size", sb_q.size(), 1);
          end else begin
            exp_r = sb_q.pop_front();
            check("sb_data", out_data, exp_r.data);
            check("sb_beats", out_beats, exp_r.beats);
          end
        end
        nxt = m_oval && !out_ready;
        if (flush) begin
          m_sum = 0;
          m_cnt = 0;
        end else if (in_valid && m_ready) begin
          m_sum += beat_q12(in_data);
          m_cnt++;
          if (in_last) begin
            sb_q.push_back({pack_sum(m_sum), m_cnt[7:0]});
            m_sum = 0;
            m_cnt = 0;
            nxt   = 1;
          end
        end
        m_oval = nxt;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ones;
    logic [255:0] d;
    c_one4 = beat4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    reset = 1'b1;  out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
    b_reset = 1'b1; b_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_flush = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    b_reset = 1'b0;

    // Reset state
    idle(); #4;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_ovf", ovf_err, 0);

    // Single-beat group: result one cycle later
    drive(1'b1, c_one4, 1'b1, 1'b0);
    idle(); #4;
    check("one_valid", out_valid, 1);
    check("one_data", out_data, 22'h0F4000);
    check("one_beats", out_beats, 1);

    // Two-beat group
    drive(1'b1, c_one4, 1'b0, 1'b0);
    drive(1'b1, c_one4, 1'b1, 1'b0);
    idle(); #4;
    check("two_data", out_data, 22'h0F8000);
    check("two_beats", out_beats, 2);

    // Backpressure: pending result blocks new beats until drained
    drive(1'b1, c_one4, 1'b1, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, c_one4, 1'b1, 1'b0); #4;
    check("bp_in_ready_lo", in_ready, 0);
    drive(1'b1, c_one4, 1'b1, 1'b0); #4;
    check("bp_in_ready_lo2", in_ready, 0);
    check("bp_hold_data", out_data, 22'h0F4000);
    drive(1'b1, c_one4, 1'b1, 1'b0);
    out_ready = 1'b1; #4;
    check("bp_in_ready_hi", in_ready, 1);
    idle(); #4;
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 22'h0F4000);
    check("bp_beats", out_beats, 1);

    // Flush between beats discards the partial sum
    drive(1'b1, c_one4, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, c_one4, 1'b1, 1'b0);
    idle(); #4;
    check("flush_data", out_data, 22'h0F4000);
    check("flush_beats", out_beats, 1);

    // Flush coinciding with a beat discards that beat too
    drive(1'b1, c_one4, 1'b0, 1'b0);
    drive(1'b1, c_one4, 1'b0, 1'b1);
    drive(1'b1, c_one4, 1'b1, 1'b0);
    idle(); #4;
    check("flushbeat_data", out_data, 22'h0F4000);
    check("flushbeat_beats", out_beats, 1);

    // Mixed signs and exponents: 2.0 then -3.0 gives -1.0
    drive(1'b1, beat4(16'h3C00, 16'hBC00, 16'h3E00, 16'h3800), 1'b0, 1'b0);
    drive(1'b1, beat4(16'hBC00, 16'hBC00, 16'hBC00, 16'h0000), 1'b1, 1'b0);
    idle(); #4;
    check("mixed_data", out_data, 22'h2FF000);
    check("mixed_beats", out_beats, 2);

    // Back-to-back single-beat groups: one result every cycle
    ones = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        d = beat4(16'h3C00, c_pat[$urandom_range(0, 4)], c_pat[$urandom_range(0, 4)],
                  c_pat[$urandom_range(0, 4)]);
        drive(1'b1, d, 1'b1, 1'b0);
      end else begin
        idle();
      end
      #4;
      if (i > 0) ones += int'(out_valid);
    end
    check("stream_no_bubble", ones, 8);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 60; i++) begin
      d = beat4(16'h3C00, c_pat[$urandom_range(0, 4)], c_pat[$urandom_range(0, 4)],
                c_pat[$urandom_range(0, 4)]);
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 2) != 0;
    end
    out_ready = 1'b1;
    repeat (4) idle();
    #4;
    check("sb_drain", sb_q.size(), 0);

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 3; i++) b_drive(1'b1, 1'b0);
    b_drive(1'b1, 1'b0); #4;
    check("sat_ovf_before", b_ovf_err, 0);
    b_drive(1'b1, 1'b1); #4;
    check("sat_ovf_after", b_ovf_err, 1);
    b_drive(1'b0, 1'b0); #4;
    check("sat_valid", b_out_valid, 1);
    check("sat_beats", b_out_beats, 3);
    check("sat_data", b_out_data, 22'h2F4000);
    repeat (3) b_drive(1'b0, 1'b0);
    #4;
    check("sat_ovf_sticky", b_ovf_err, 1);
    @(negedge clock);
    b_reset = 1'b1;
    @(negedge clock);
    b_reset = 1'b0; #4;
    check("sat_ovf_reset", b_ovf_err, 0);
    check("sat_valid_reset", b_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
